// File: rtl/bin2qdi_e1ofn_fifo_if.sv
// Bundled producer/consumer signals of the binary-to-QDI token source.
// master = clocked producer plus QDI receiver side, slave = the converter itself.
interface bin2qdi_e1ofn_fifo_if #(
    parameter int W  = 8,
    parameter int CW = 3
);
    logic [W-1:0]   din;
    logic           din_valid;
    logic           din_ready;
    logic [2*W-1:0] R;
    logic           Re;
    logic [CW-1:0]  count;
    logic           err_proto;

    modport master (
        output din, din_valid, Re,
        input  din_ready, R, count, err_proto
    );

    modport slave (
        input  din, din_valid, Re,
        output din_ready, R, count, err_proto
    );
endinterface

// File: rtl/bin2qdi_e1ofn_fifo.sv
// Buffers clocked binary words and emits them as four-phase e1of2 or e1of4 QDI tokens.
// The token being driven lives in R; count covers only words still waiting in the FIFO.
//
//   state     | meaning
//   S_NEUTRAL | R=0, waiting for Re_s high
//   S_IDLE    | R=0, ready to launch the FIFO head when Re_s high
//   S_DRIVE   | R holds a valid code until Re_s falls
module bin2qdi_e1ofn_fifo #(
    parameter int W           = 8,
    parameter int DEPTH       = 4,
    parameter int ENC         = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                _RESET,
    bin2qdi_e1ofn_fifo_if.slave bus,
    inout  wire                 VDD,
    inout  wire                 GND
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_NEUTRAL, S_IDLE, S_DRIVE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] re_sync_q;
    logic                   re_s;
    logic [W-1:0]           mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   ready_q, ready_d;
    logic [2*W-1:0]         r_q, r_d;
    logic                   err_q, err_d;
    logic                   push, pop;

    wire unused_supply = VDD ^ GND;

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
        logic [2*W-1:0] e;
        e = '0;
        if (ENC == 0) begin
            for (int i = 0; i < W; i++) begin
                e[2*i]   = ~v[i];
                e[2*i+1] = v[i];
            end
        end else begin
            for (int j = 0; j < W/2; j++)
                for (int k = 0; k < 4; k++)
                    e[4*j+k] = (v[2*j +: 2] == 2'(k));
        end
        return e;
    endfunction

    assign re_s = re_sync_q[SYNC_STAGES-1];
    assign push = bus.din_valid && ready_q;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) re_sync_q <= '0;
        else         re_sync_q <= {re_sync_q[SYNC_STAGES-2:0], bus.Re};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        err_d   = err_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (re_s && count_q != '0) begin
                    r_d     = enc(mem_q[rd_ptr_q]);
                    pop     = 1'b1;
                    state_d = S_DRIVE;
                end else if (!re_s) begin
                    // acknowledge arrived with nothing on the rails
                    err_d = 1'b1;
                end
            end
            S_DRIVE: begin
                if (!re_s) begin
                    r_d     = '0;
                    state_d = S_NEUTRAL;
                end
            end
            S_NEUTRAL: begin
                if (re_s) state_d = S_IDLE;
            end
            default: begin
                r_d     = '0;
                state_d = S_NEUTRAL;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q  <= S_NEUTRAL;
            r_q      <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            err_q   <= err_d;
            count_q <= count_d;
            ready_q <= ready_d;
            if (push)
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);
        end
    end

    // storage is not reset; the pointers define what is valid
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.din;
    end

    assign bus.R         = r_q;
    assign bus.din_ready = ready_q;
    assign bus.count     = count_q;
    assign bus.err_proto = err_q;
endmodule

// File: tb/tb_bin2qdi_e1ofn_fifo.sv
// Directed bench: a dual-rail and a 1of4 instance (W=4, DEPTH=4, SYNC_STAGES=2)
// driven from a vector table plus hand-written FIFO, protocol and reset sequences.
module tb_bin2qdi_e1ofn_fifo;
    logic clk = 1'b0;
    logic rst_b;
    wire  vdd = 1'b1;
    wire  gnd = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin2qdi_e1ofn_fifo_if #(.W(4), .CW(3)) ba ();
    bin2qdi_e1ofn_fifo_if #(.W(4), .CW(3)) bb ();

    bin2qdi_e1ofn_fifo #(.W(4), .DEPTH(4), .ENC(0), .SYNC_STAGES(2)) dut_a (
        .CLK(clk), ._RESET(rst_b), .bus(ba), .VDD(vdd), .GND(gnd));
    bin2qdi_e1ofn_fifo #(.W(4), .DEPTH(4), .ENC(1), .SYNC_STAGES(2)) dut_b (
        .CLK(clk), ._RESET(rst_b), .bus(bb), .VDD(vdd), .GND(gnd));

    typedef struct {
        logic [3:0] din;
        logic [7:0] r_enc0;
        logic [7:0] r_enc1;
    } vec_t;

    vec_t       vecs [6];
    logic [3:0] fw   [6];
    logic [7:0] fr   [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [3:0] d);
        ba.din       = d;
        ba.din_valid = 1'b1;
        tick();
        ba.din_valid = 1'b0;
    endtask

    // A must be in DRIVE: return to neutral, then relaunch and check the next code
    task automatic cycle_a(input logic [7:0] exp_r, input string name);
        ba.Re = 1'b0;
        repeat (3) tick();
        chk({name, "_neutral"}, 32'(ba.R), 32'h00);
        ba.Re = 1'b1;
        repeat (4) tick();
        chk(name, 32'(ba.R), 32'(exp_r));
    endtask

    initial begin
        int acc;

        vecs[0] = '{4'hA, 8'h99, 8'h44};
        vecs[1] = '{4'h3, 8'h5A, 8'h18};
        vecs[2] = '{4'h0, 8'h55, 8'h11};
        vecs[3] = '{4'hF, 8'hAA, 8'h88};
        vecs[4] = '{4'h6, 8'h69, 8'h24};
        vecs[5] = '{4'h9, 8'h96, 8'h42};

        fw = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        fr = '{8'h56, 8'h59, 8'h5A, 8'h65, 8'h66, 8'h69};

        rst_b = 1'b0;
        ba.din = '0; ba.din_valid = 1'b0; ba.Re = 1'b1;
        bb.din = '0; bb.din_valid = 1'b0; bb.Re = 1'b1;
        repeat (2) tick();
        chk("rst_R", 32'(ba.R), 32'h0);
        chk("rst_count", 32'(ba.count), 32'h0);
        chk("rst_ready", 32'(ba.din_ready), 32'h0);
        chk("rst_err", 32'(ba.err_proto), 32'h0);

        rst_b = 1'b1;
        tick();
        chk("ready_after_release", 32'(ba.din_ready), 32'h1);
        repeat (3) tick();

        for (int v = 0; v < 6; v++) begin
            ba.din = vecs[v].din; ba.din_valid = 1'b1;
            bb.din = vecs[v].din; bb.din_valid = 1'b1;
            tick();
            ba.din_valid = 1'b0; bb.din_valid = 1'b0;
            chk("vec_count_push", 32'(ba.count), 32'h1);
            chk("vec_R_before_launch", 32'(ba.R), 32'h0);
            tick();
            chk("vec_enc0", 32'(ba.R), 32'(vecs[v].r_enc0));
            chk("vec_enc1", 32'(bb.R), 32'(vecs[v].r_enc1));
            chk("vec_count_drive", 32'(ba.count), 32'h0);
            tick();
            chk("vec_hold", 32'(ba.R), 32'(vecs[v].r_enc0));
            ba.Re = 1'b0; bb.Re = 1'b0;
            repeat (2) tick();
            chk("vec_hold_2edges", 32'(ba.R), 32'(vecs[v].r_enc0));
            tick();
            chk("vec_neutral_a", 32'(ba.R), 32'h0);
            chk("vec_neutral_b", 32'(bb.R), 32'h0);
            ba.Re = 1'b1; bb.Re = 1'b1;
            repeat (3) tick();
        end

        // fill: one word launches, four queue, the sixth is refused
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            ba.din = fw[i];
            ba.din_valid = 1'b1;
            if (ba.din_ready) acc++;
            tick();
        end
        ba.din_valid = 1'b0;
        chk("fill_accepts", 32'(acc), 32'd5);
        chk("fill_ready_low", 32'(ba.din_ready), 32'h0);
        chk("fill_count", 32'(ba.count), 32'h4);
        chk("fill_first", 32'(ba.R), 32'(fr[0]));
        cycle_a(fr[1], "fifo_w2");
        chk("ready_after_pop", 32'(ba.din_ready), 32'h1);
        chk("count_after_pop", 32'(ba.count), 32'h3);
        for (int i = 2; i < 5; i++) cycle_a(fr[i], "fifo_order");
        cycle_a(8'h00, "fifo_drained");
        chk("fifo_count_zero", 32'(ba.count), 32'h0);

        // simultaneous push and pop with two words waiting
        ba.din_valid = 1'b1;
        ba.din = 4'h7; tick();
        ba.din = 4'h8; tick();
        ba.din = 4'h9; tick();
        ba.din_valid = 1'b0;
        chk("pp_count_pre", 32'(ba.count), 32'h2);
        chk("pp_first", 32'(ba.R), 32'h6A);
        ba.Re = 1'b0;
        repeat (3) tick();
        chk("pp_neutral", 32'(ba.R), 32'h0);
        ba.Re = 1'b1;
        repeat (3) tick();
        push_a(4'hA);
        chk("pp_count_same_edge", 32'(ba.count), 32'h2);
        chk("pp_second", 32'(ba.R), 32'h95);
        cycle_a(8'h96, "pp_third");
        chk("pp_count_1", 32'(ba.count), 32'h1);
        cycle_a(8'h99, "pp_fourth");
        chk("pp_count_0", 32'(ba.count), 32'h0);
        cycle_a(8'h00, "pp_no_dup");

        // acknowledge with nothing driven
        chk("err_before", 32'(ba.err_proto), 32'h0);
        ba.Re = 1'b0;
        repeat (4) tick();
        chk("err_set", 32'(ba.err_proto), 32'h1);
        chk("err_R_zero", 32'(ba.R), 32'h0);
        ba.Re = 1'b1;
        repeat (4) tick();
        push_a(4'h6);
        tick();
        chk("err_then_emit", 32'(ba.R), 32'h69);
        chk("err_sticky", 32'(ba.err_proto), 32'h1);
        chk("err_other_clean", 32'(bb.err_proto), 32'h0);

        // reset while driving with three words queued
        ba.din_valid = 1'b1;
        ba.din = 4'h1; tick();
        ba.din = 4'h2; tick();
        ba.din = 4'h3; tick();
        ba.din_valid = 1'b0;
        chk("mid_count", 32'(ba.count), 32'h3);
        chk("mid_drive", 32'(ba.R), 32'h69);
        #2;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_R", 32'(ba.R), 32'h0);
        chk("mid_rst_count", 32'(ba.count), 32'h0);
        chk("mid_rst_ready", 32'(ba.din_ready), 32'h0);
        tick();
        rst_b = 1'b1;
        repeat (4) tick();
        push_a(4'hC);
        chk("post_rst_count", 32'(ba.count), 32'h1);
        tick();
        chk("post_rst_word", 32'(ba.R), 32'hA5);
        chk("post_rst_err_clear", 32'(ba.err_proto), 32'h0);
        cycle_a(8'h00, "post_rst_no_replay");
        chk("post_rst_count_end", 32'(ba.count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
